// File: rtl/freq_hop_sched.sv
// freq_hop_sched: round-robin synthesizer retune scheduler with settle delay and lock check
module freq_hop_sched #(
    parameter int N_REQ     = 4,
    parameter int M         = 8,
    parameter int SETTLE    = 16,
    parameter int WINDOW    = 32,
    parameter int MIN_TOG   = 1,
    parameter int CTRL_INIT = 1
) (
    input  logic                     ref_clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*M-1:0]       req_ctrl,
    input  logic                     syn_clk,
    output logic [M-1:0]             ctrl,
    output logic [N_REQ-1:0]         ack,
    output logic                     ack_ok,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic [7:0]               err_cnt
);
    localparam int GW = $clog2(N_REQ);
    localparam logic [7:0] SET_LD = 8'(SETTLE - 1);
    localparam logic [7:0] WIN_LD = 8'(WINDOW - 1);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_RESP} state_t;
    state_t state, nxt;
    logic [GW-1:0] pick, idx, rr_ptr;
    logic [M-1:0] word;
    logic [7:0] cnt, tog;
    logic syn_q, bad, grant;

    // Round-robin pick: the pending requester closest after rr_ptr wins
    always_comb begin
        pick = '0;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = GW'((int'(rr_ptr) + k) % N_REQ);
            if (req[idx]) pick = idx;
        end
        word = M'(req_ctrl >> (int'(pick) * M));
        grant = state == S_IDLE && |req;
    end

    // Next state and response outputs
    always_comb begin
        nxt = state;
        ack = '0;
        ack_ok = 1'b0;
        busy = state != S_IDLE;
        case (state)
            S_IDLE:   nxt = grant ? (word != '0 ? S_SETTLE : S_RESP) : S_IDLE;
            S_SETTLE: nxt = cnt == '0 ? S_CHECK : S_SETTLE;
            S_CHECK:  nxt = cnt == '0 ? S_RESP : S_CHECK;
            default: begin
                nxt = S_IDLE;
                ack[grant_id] = 1'b1;
                ack_ok = !bad && 32'(tog) >= MIN_TOG;
            end
        endcase
    end

    // State register
    always_ff @(posedge ref_clk)
        state <= rst ? S_IDLE : nxt;

    // Grant latch, control word, phase timer, toggle counter and error counter
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            ctrl <= M'(CTRL_INIT);
            grant_id <= '0;
            rr_ptr <= '0;
            cnt <= '0;
            tog <= '0;
            syn_q <= 1'b0;
            bad <= 1'b0;
            err_cnt <= '0;
        end else begin
            syn_q <= syn_clk;
            if (grant) begin
                grant_id <= pick;
                rr_ptr <= (pick == GW'(N_REQ - 1)) ? '0 : pick + GW'(1);
                bad <= word == '0;
                cnt <= SET_LD;
                if (word != '0) ctrl <= word;
            end
            if (state == S_SETTLE) begin
                cnt <= (cnt == '0) ? WIN_LD : cnt - 8'd1;
                if (cnt == '0) tog <= '0;
            end
            if (state == S_CHECK) begin
                if (cnt != '0) cnt <= cnt - 8'd1;
                if (syn_clk != syn_q && tog != 8'hFF) tog <= tog + 8'd1;
            end
            if (state == S_RESP && !ack_ok && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_freq_hop_sched.sv
// tb_freq_hop_sched: randomized scoreboard bench for freq_hop_sched
module tb_freq_hop_sched;
    localparam int N = 4, M = 8, ST = 4, WN = 8, MT = 1;
    localparam int VL = ST + WN + 1;
    typedef struct {
        logic [3:0] ack;
        logic       ok;
        logic [7:0] ctrl;
        logic [7:0] err_b;
        logic [7:0] err_a;
        logic [1:0] gid;
        int         due;
    } exp_t;

    logic ref_clk = 1'b0, rst = 1'b1, syn_clk = 1'b0;
    logic [N-1:0] req = '0;
    logic [N*M-1:0] req_ctrl = '0;
    logic [M-1:0] ctrl;
    logic [N-1:0] ack;
    logic ack_ok, busy;
    logic [1:0] grant_id;
    logic [7:0] err_cnt;

    exp_t sb [$];
    int cyc = 0, n_chk = 0, n_pass = 0;
    int ptr_m = 0, err_m = 0;
    logic [7:0] ctrl_m = 8'd1;
    logic last_syn = 1'b0, mon_on = 1'b0;

    freq_hop_sched #(.N_REQ(N), .M(M), .SETTLE(ST), .WINDOW(WN), .MIN_TOG(MT), .CTRL_INIT(1)) dut (
        .ref_clk(ref_clk), .rst(rst), .req(req), .req_ctrl(req_ctrl), .syn_clk(syn_clk),
        .ctrl(ctrl), .ack(ack), .ack_ok(ack_ok), .busy(busy), .grant_id(grant_id), .err_cnt(err_cnt)
    );

    always #5 ref_clk = ~ref_clk;
    always @(posedge ref_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, want, cyc);
    endtask

    // Plan one round of requests with the reference model, push expectations, then drive it
    task automatic run_round(input logic [3:0] mask, input logic [31:0] words, input logic [7:0] modes, input int reps);
        int left [4];
        int gs [$];
        int ids [$];
        logic [3:0] rq [128];
        logic [31:0] rc [128];
        logic fl [128];
        logic sy [128];
        exp_t tq [$];
        exp_t e;
        int g = 0, i, len, gap, base, cnt, l;
        logic [7:0] w, ctrl_first;
        logic [1:0] m;
        ctrl_first = ctrl_m;
        for (int k = 0; k < 4; k++) left[k] = mask[k] ? reps : 0;
        for (int r = 0; r < 128; r++) begin
            rq[r] = 4'($urandom);
            rc[r] = $urandom;
            fl[r] = 1'($urandom);
        end
        while (left[0] + left[1] + left[2] + left[3] > 0) begin
            i = ptr_m;
            while (left[i] == 0) i = (i + 1) % 4;
            w = words[i*8 +: 8];
            l = (w != 0) ? VL : 1;
            for (int k = 0; k < 4; k++) rq[g][k] = left[k] > 0;
            rc[g] = words;
            m = modes[2*i +: 2];
            for (int r = g + 1; r <= g + l; r++)
                fl[r] = (m == 2'd1) ? 1'b1 : (m == 2'd2) ? 1'($urandom) : (m == 2'd3 && r <= g + ST);
            gs.push_back(g);
            ids.push_back(i);
            left[i]--;
            ptr_m = (i + 1) % 4;
            g += l + 1;
        end
        gap = $urandom_range(0, 2);
        for (int r = g; r < g + gap; r++) rq[r] = '0;
        len = g + gap;
        sy[0] = last_syn ^ fl[0];
        for (int r = 1; r < len; r++) sy[r] = sy[r-1] ^ fl[r];
        for (int k = 0; k < gs.size(); k++) begin
            g = gs[k];
            i = ids[k];
            w = words[i*8 +: 8];
            l = (w != 0) ? VL : 1;
            cnt = 0;
            if (w != 0) for (int r = g + ST + 1; r <= g + ST + WN; r++) cnt += int'(fl[r]);
            if (w != 0) ctrl_m = w;
            if (k == 0) ctrl_first = ctrl_m;
            e.ack = 4'(1 << i);
            e.ok = w != 0 && cnt >= MT;
            e.ctrl = ctrl_m;
            e.gid = 2'(i);
            e.err_b = 8'(err_m);
            if (!e.ok && err_m < 255) err_m++;
            e.err_a = 8'(err_m);
            e.due = g + l - 1;
            tq.push_back(e);
        end
        for (int r = 0; r < len; r++) begin
            @(negedge ref_clk);
            if (r == 0) begin
                base = cyc + 1;
                foreach (tq[k]) begin
                    e = tq[k];
                    e.due += base;
                    sb.push_back(e);
                end
            end
            if (r == 1) begin
                chk("ctrl_at_grant", ctrl, ctrl_first);
                chk("busy_at_grant", busy, 1);
                chk("grant_first", grant_id, ids[0]);
            end
            rst = 1'b0;
            req = rq[r];
            req_ctrl = rc[r];
            syn_clk = sy[r];
        end
        last_syn = sy[len-1];
    endtask

    // Monitor: pop and compare whenever the DUT presents an ack
    initial begin
        logic post;
        logic [7:0] err_next;
        exp_t e;
        post = 1'b0;
        err_next = '0;
        wait (mon_on);
        forever begin
            @(posedge ref_clk);
            #1;
            if (post) begin
                chk("busy_after_ack", busy, 0);
                chk("err_after_ack", err_cnt, err_next);
            end
            post = 1'b0;
            while (sb.size() > 0 && sb[0].due < cyc) begin
                $display("FAIL missing_ack: got no ack by cycle %0d, expected %b", sb[0].due, sb[0].ack);
                n_chk++;
                void'(sb.pop_front());
            end
            if (ack != '0) begin
                if (sb.size() == 0) begin
                    $display("FAIL spurious_ack: got %b, expected none (cycle %0d)", ack, cyc);
                    n_chk++;
                end else begin
                    e = sb.pop_front();
                    chk("ack", ack, e.ack);
                    chk("ack_ok", ack_ok, e.ok);
                    chk("ack_cycle", cyc, e.due);
                    chk("grant_id", grant_id, e.gid);
                    chk("ctrl_at_ack", ctrl, e.ctrl);
                    chk("err_at_ack", err_cnt, e.err_b);
                    post = 1'b1;
                    err_next = e.err_a;
                end
            end else chk("ack_ok_without_ack", ack_ok, 0);
        end
    end

    initial begin
        repeat (60000) @(posedge ref_clk);
        $display("FAIL watchdog: got no completion by cycle %0d, expected finish", cyc);
        n_chk++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        logic [31:0] wd;
        repeat (3) @(negedge ref_clk);
        chk("rst_ctrl", ctrl, 1);
        chk("rst_ack", ack, 0);
        chk("rst_ack_ok", ack_ok, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_err_cnt", err_cnt, 0);
        mon_on = 1'b1;
        run_round(4'b1111, 32'h44332211, 8'b01010101, 1);
        run_round(4'b0001, 32'h00000005, 8'b00000001, 1);
        run_round(4'b0100, 32'h00000000, 8'h00, 1);
        run_round(4'b0010, 32'h00009900, 8'b00001100, 1);
        run_round(4'b1111, 32'hA0B000C0, 8'b10011001, 2);
        for (int n = 0; n < 30; n++) begin
            wd = $urandom;
            for (int k = 0; k < 4; k++) if ($urandom_range(0, 3) == 0) wd[k*8 +: 8] = '0;
            run_round(4'($urandom_range(1, 15)), wd, 8'($urandom), $urandom_range(1, 2));
        end
        for (int n = 0; n < 70; n++) run_round(4'b1111, 32'h11223344, 8'h00, 1);
        @(negedge ref_clk);
        req = 4'b0001;
        req_ctrl = 32'h00000033;
        repeat (7) @(negedge ref_clk);
        rst = 1'b1;
        req = 4'b1010;
        req_ctrl = 32'h77006600;
        @(negedge ref_clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_ctrl", ctrl, 1);
        chk("midrst_ack", ack, 0);
        chk("midrst_ack_ok", ack_ok, 0);
        chk("midrst_grant_id", grant_id, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        ptr_m = 0;
        err_m = 0;
        ctrl_m = 8'd1;
        run_round(4'b1010, 32'h77006600, 8'b01000100, 1);
        @(negedge ref_clk);
        req = '0;
        repeat (30) @(negedge ref_clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/freq_hop_sched.md
FREQ_HOP_SCHED -- requirements
Module: freq_hop_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters.
REQ-002 SHALL have parameter M, default 8, width of the synthesizer control word.
REQ-003 SHALL have parameter SETTLE, default 16, settle cycles after a retune (range 1..255).
REQ-004 SHALL have parameter WINDOW, default 32, lock-check window in cycles (range 1..255).
REQ-005 SHALL have parameter MIN_TOG, default 1, minimum syn_clk toggles in the window for lock pass.
REQ-006 SHALL have parameter CTRL_INIT, default 1, nonzero control word applied at reset.
REQ-007 ref_clk  input  1  single clock; all logic on its rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 req  input  N_REQ  per-requester retune request, level, held until ack.
REQ-010 req_ctrl  input  N_REQ*M  requested control word, slice i belongs to requester i.
REQ-011 syn_clk  input  1  synthesizer output, synchronous to ref_clk.
REQ-012 ctrl  output  M  registered control word driven to the synthesizer.
REQ-013 ack  output  N_REQ  one-hot, one-cycle completion pulse to the granted requester.
REQ-014 ack_ok  output  1  valid with ack; 1 = retune applied and lock check passed.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 grant_id  output  clog2(N_REQ)  index of the current/last granted requester.
REQ-017 err_cnt  output  8  saturating count of failed (ack_ok=0) responses.

Function
REQ-018 SHALL implement states IDLE, SETTLE, CHECK, RESP.
REQ-019 IDLE: at an edge with req != 0, SHALL grant by round-robin starting from the index after the last grant (index 0 first after reset), latch grant_id, and leave IDLE.
REQ-020 req SHALL be sampled only in IDLE; changes to req or req_ctrl outside IDLE SHALL be ignored.
REQ-021 Granted word nonzero: ctrl SHALL load it at the grant edge; next state SETTLE.
REQ-022 Granted word zero: ctrl SHALL remain unchanged (no divide-by-zero); next state RESP with ack_ok=0.
REQ-023 SETTLE SHALL last exactly SETTLE cycles, then go to CHECK.
REQ-024 CHECK SHALL last exactly WINDOW cycles, counting cycles where syn_clk differs from its value registered the previous cycle; the count SHALL saturate at 255.
REQ-025 The toggle counter SHALL clear on entry to CHECK; toggles outside CHECK SHALL not count.
REQ-026 RESP SHALL last one cycle: ack[grant_id]=1, ack_ok = (toggle count >= MIN_TOG), then IDLE.
REQ-027 Valid-word latency: grant edge to ack high SHALL be SETTLE+WINDOW+1 cycles; zero-word latency SHALL be 1 cycle.
REQ-028 ack SHALL be zero outside RESP; ack_ok SHALL be zero when ack is zero.
REQ-029 err_cnt SHALL increment in each RESP with ack_ok=0 and hold at 255.
REQ-030 A requester still holding req after its ack SHALL be granted again only after all other pending requesters in round-robin order.
REQ-031 ctrl SHALL change only at a grant edge with a nonzero word, or on reset.

Reset
REQ-032 rst SHALL, in any state including mid-SETTLE/CHECK: state=IDLE, ctrl=CTRL_INIT, ack=0, ack_ok=0, busy=0, grant_id=0, round-robin pointer to 0, err_cnt=0, toggle counter=0, syn_clk register=0.
REQ-033 A request pending when rst deasserts SHALL be granted at the first edge after rst deassertion.

Verification (N_REQ=4, M=8, SETTLE=4, WINDOW=8, MIN_TOG=1)
REQ-034 req=0001, req_ctrl[0]=8'h05, syn_clk toggling -> ctrl=5 at grant edge, ack=0001 with ack_ok=1 exactly 13 cycles later, busy low next cycle.
REQ-035 req=1111 held through three acks -> grants in order 0,1,2,3, each ack one-hot and ack_ok per syn_clk activity.
REQ-036 req=0100, req_ctrl[2]=0 -> ctrl unchanged, ack=0100 with ack_ok=0 the next cycle, err_cnt=1.
REQ-037 Valid word, syn_clk held constant -> ack_ok=0, err_cnt increments; 256 such fails -> err_cnt stays 255.
REQ-038 rst asserted during CHECK -> next cycle IDLE, ctrl=CTRL_INIT, no ack issued; pending req granted at first edge after deassertion.
REQ-039 syn_clk toggles only during SETTLE, constant in CHECK -> ack_ok=0.
